// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the EX stage and the iterative multiply/divide unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       alu_ctr;
  logic             is_signed;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, alu_ctr, is_signed, src_a, src_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, alu_ctr, is_signed, src_a, src_b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers, 34-cycle fixed latency.
// Define MDU_DIV_EN to include the restoring divider; without it only mul is accepted.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  mul_div_unit_if.slave bus
);

  localparam logic [3:0] ALU_MUL = 4'b1011;
`ifdef MDU_DIV_EN
  localparam logic [3:0] ALU_DIV = 4'b1100;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [4:0]         cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               neg_lo;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               legal, accept;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] prod_fix;
`ifdef MDU_DIV_EN
  logic               op_div, neg_hi, div0;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [2*WIDTH-1:0] div_step;
`endif

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

`ifdef MDU_DIV_EN
  assign legal = (bus.alu_ctr == ALU_MUL) || (bus.alu_ctr == ALU_DIV);
`else
  assign legal = (bus.alu_ctr == ALU_MUL);
`endif
  assign accept = (state == IDLE) && bus.start && legal && !bus.flush;

  // Shift-add: acc holds {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};
  assign prod_fix = neg_dw(acc, neg_lo);

`ifdef MDU_DIV_EN
  // Restoring divide: acc holds {remainder, dividend bits shifting into quotient}
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opb};
  assign div_step = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (bus.flush)          state_nxt = IDLE;
        else if (cnt == 5'd31)  state_nxt = FIX;
      end
      FIX:  state_nxt = bus.flush ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      neg_lo <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef MDU_DIV_EN
      op_div <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt    <= '0;
        neg_lo <= bus.is_signed && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
`ifdef MDU_DIV_EN
        op_div <= (bus.alu_ctr == ALU_DIV);
        neg_hi <= bus.is_signed && bus.src_a[WIDTH-1];
        div0   <= (bus.src_b == '0);
        if (bus.alu_ctr == ALU_DIV) begin
          acc <= {{WIDTH{1'b0}}, mag(bus.src_a, bus.is_signed)};
          opb <= mag(bus.src_b, bus.is_signed);
        end else begin
          acc <= {{WIDTH{1'b0}}, mag(bus.src_b, bus.is_signed)};
          opb <= mag(bus.src_a, bus.is_signed);
        end
`else
        acc <= {{WIDTH{1'b0}}, mag(bus.src_b, bus.is_signed)};
        opb <= mag(bus.src_a, bus.is_signed);
`endif
      end else if (state == RUN) begin
        cnt <= cnt + 5'd1;
`ifdef MDU_DIV_EN
        acc <= op_div ? div_step : mul_step;
`else
        acc <= mul_step;
`endif
      end

      // Divide-by-zero: undoing the dividend sign on the remainder restores src_a exactly
      if (state == FIX && !bus.flush) begin
`ifdef MDU_DIV_EN
        if (op_div) begin
          hi_q <= neg_w(acc[2*WIDTH-1:WIDTH], neg_hi);
          lo_q <= div0 ? {WIDTH{1'b1}} : neg_w(acc[WIDTH-1:0], neg_lo);
        end else begin
          hi_q <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q <= prod_fix[WIDTH-1:0];
        end
`else
        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
        lo_q <= prod_fix[WIDTH-1:0];
`endif
      end
    end
  end

  assign bus.busy = (state == RUN) || (state == FIX);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
